// File: rtl/sb_pkg.sv
// Shared types and sizing for the store buffer.
// An entry holds a word address and a full data word.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [SB_AW-3:0]  waddr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational youngest-first search of the pending stores for a load address.
// Offset 0 is the entry just behind the tail, so the lowest matching offset wins.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  sb_entry_t [DEPTH-1:0]         entries,
    input  logic [$clog2(DEPTH)-1:0]      tail,
    input  logic [AW-3:0]                 addr,
    output logic                          hit,
    output logic [DW-1:0]                 data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx [DEPTH];
    logic [DEPTH-1:0] match;

    // idx wraps naturally modulo DEPTH; offset DEPTH-1 reaches the oldest slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign idx[gi]   = tail - PTR_W'(gi + 1);
            assign match[gi] = entries[idx[gi]].valid && (entries[idx[gi]].waddr == addr);
        end
    endgenerate

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit  = 1'b1;
                data = entries[idx[k]].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending CPU stores draining to a single-port data memory whenever
// no load owns the port; loads see the youngest pending store to their word.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_we,
    input  logic                       cpu_re,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    output logic [DW-1:0]              cpu_rdata,
    output logic                       stall,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [DW-1:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0] entries_reg;
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [CNT_W-1:0]      count_reg;

    logic          full;
    logic          is_empty;
    logic          enq;
    logic          drain;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    // full comes from the registered count only, so a same-cycle drain never frees a slot.
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);
    assign enq      = cpu_we & ~full;
    // A load claims the port even when it illegally overlaps a store.
    assign drain    = ~is_empty & ~cpu_re;

    always_ff @(posedge clk) begin
        if (reset) begin
            entries_reg <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
        end else begin
            if (enq) begin
                entries_reg[tail_reg] <= '{valid: 1'b1, waddr: cpu_addr[AW-1:2], data: cpu_wdata};
                tail_reg              <= tail_reg + 1'b1;
            end
            if (drain) begin
                entries_reg[head_reg].valid <= 1'b0;
                head_reg                    <= head_reg + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .entries (entries_reg),
        .tail    (tail_reg),
        .addr    (cpu_addr[AW-1:2]),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    assign mem_we    = ~reset & drain;
    assign mem_addr  = cpu_re ? cpu_addr : {entries_reg[head_reg].waddr, 2'b00};
    assign mem_wdata = entries_reg[head_reg].data;
    assign stall     = ~reset & cpu_we & full;
    assign empty     = reset | is_empty;
    assign count     = count_reg;
    assign cpu_rdata = (cpu_re & fwd_hit) ? fwd_data : mem_rdata;

endmodule
